// File: rtl/peripheral_ahb4_spram_ws.sv
// rtl/peripheral_ahb4_spram_ws.sv - AHB-Lite single-port SRAM slave with byte lanes, wait states and ERROR responses
module peripheral_ahb4_spram_ws #(
    parameter int XLEN              = 32,
    parameter int PLEN              = 12,
    parameter int MEM_DEPTH         = 256,
    parameter int WAIT_STATES       = 0,
    parameter int REGISTERED_OUTPUT = 0,
    parameter int ERR_ON_OOR        = 1
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            HSEL,
    input  logic [PLEN-1:0] HADDR,
    input  logic [XLEN-1:0] HWDATA,
    output logic [XLEN-1:0] HRDATA,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [3:0]      HPROT,
    input  logic [1:0]      HTRANS,
    input  logic            HMASTLOCK,
    output logic            HREADYOUT,
    input  logic            HREADY,
    output logic            HRESP
);

    localparam int BYTES = XLEN / 8;
    localparam int ALSB  = $clog2(BYTES);
    localparam int IW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int FW    = PLEN - ALSB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [BYTES-1:0] mask_q, mask_d;
    logic [XLEN-1:0]  rdata_q, rdata_d;
    logic [XLEN-1:0]  hrdata_q, hrdata_d;
    logic             pend_v_q, pend_v_d;
    logic [IW-1:0]    pend_idx_q, pend_idx_d;
    logic [BYTES-1:0] pend_mask_q, pend_mask_d;
    logic [XLEN-1:0]  pend_data_q, pend_data_d;

    logic [XLEN-1:0]  mem_array [MEM_DEPTH];

    logic [15:0]      size_ones;
    logic [FW-1:0]    acc_widx;
    logic [ALSB-1:0]  acc_off;
    logic [IW-1:0]    acc_idx;
    logic [BYTES-1:0] acc_mask;
    logic [2:0]       acc_n;
    logic             size_err, align_err, oor_err;
    logic             acc, acc_err, acc_ok;
    logic             commit, rd_launch, drain, load_hr;
    logic [XLEN-1:0]  mem_rd, read_out;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0]  base,
                                                   input logic [BYTES-1:0] mask,
                                                   input logic [XLEN-1:0]  data);
        logic [XLEN-1:0] res;
        res = base;
        for (int b = 0; b < BYTES; b++) begin
            if (mask[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

    // Bytes-per-beat as a run of ones; doubles as the lane pattern and the alignment mask
    always_comb begin
        case (HSIZE)
            3'd0:    size_ones = 16'h0001;
            3'd1:    size_ones = 16'h0003;
            3'd2:    size_ones = 16'h000F;
            default: size_ones = 16'h00FF;
        endcase
    end

    assign acc_widx  = HADDR[PLEN-1:ALSB];
    assign acc_off   = HADDR[ALSB-1:0];
    assign size_err  = HSIZE > 3'(ALSB);
    assign align_err = |(acc_off & ALSB'(size_ones >> 1));
    assign oor_err   = (ERR_ON_OOR != 0) && (32'(acc_widx) >= 32'(MEM_DEPTH));
    assign acc_idx   = IW'(32'(acc_widx) % 32'(MEM_DEPTH));
    assign acc_mask  = BYTES'(size_ones << acc_off);
    assign acc_n     = HWRITE ? 3'(WAIT_STATES) : 3'(WAIT_STATES + REGISTERED_OUTPUT);

    // A new address phase is only sampled while the slave is driving HREADYOUT high
    assign acc       = HSEL && HREADY && HTRANS[1] && (state_q != S_WAIT) && (state_q != S_ERR1);
    assign acc_err   = acc && (size_err || align_err || oor_err);
    assign acc_ok    = acc && !(size_err || align_err || oor_err);

    // The array port is taken by a read launch; the pending write drains whenever it is free,
    // or is forced out when a newer write needs the buffer
    assign commit    = (state_q == S_DONE) && write_q;
    assign rd_launch = acc_ok && !HWRITE;
    assign drain     = pend_v_q && (!rd_launch || commit);
    assign mem_rd    = mem_array[acc_idx];

    assign load_hr   = (REGISTERED_OUTPUT != 0) ? ((state_q == S_WAIT) && (cnt_q == 3'd0) && !write_q)
                                                : ((state_q == S_DONE) && !write_q);

    // Transfer FSM: address-phase capture, wait countdown and two-cycle error response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 3'd0) state_d = S_DONE;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (acc_err) begin
                    state_d = S_ERR1;
                end else if (acc_ok) begin
                    write_d = HWRITE;
                    idx_d   = acc_idx;
                    mask_d  = acc_mask;
                    if (acc_n != 3'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = acc_n - 3'd1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
        endcase
    end

    // Pending-write buffer, read capture with forwarding, and held read data
    always_comb begin
        pend_v_d    = pend_v_q;
        pend_idx_d  = pend_idx_q;
        pend_mask_d = pend_mask_q;
        pend_data_d = pend_data_q;
        if (commit) begin
            pend_v_d    = 1'b1;
            pend_idx_d  = idx_q;
            pend_mask_d = mask_q;
            pend_data_d = HWDATA;
        end else if (drain) begin
            pend_v_d    = 1'b0;
        end

        read_out = (pend_v_q && (pend_idx_q == idx_q))
                 ? merge_lanes(rdata_q, pend_mask_q, pend_data_q) : rdata_q;

        // A drain that lands on a word already captured for an in-flight read patches the capture,
        // so the lanes are not lost when the buffer empties before the data phase ends
        rdata_d = rdata_q;
        if (rd_launch) begin
            rdata_d = (drain && (pend_idx_q == acc_idx))
                    ? merge_lanes(mem_rd, pend_mask_q, pend_data_q) : mem_rd;
        end else if (drain && (pend_idx_q == idx_q)) begin
            rdata_d = merge_lanes(rdata_q, pend_mask_q, pend_data_q);
        end

        hrdata_d = hrdata_q;
        if (load_hr) hrdata_d = read_out;
    end

    // Control and datapath registers
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            mask_q      <= '0;
            rdata_q     <= '0;
            hrdata_q    <= '0;
            pend_v_q    <= 1'b0;
            pend_idx_q  <= '0;
            pend_mask_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
            hrdata_q    <= hrdata_d;
            pend_v_q    <= pend_v_d;
            pend_idx_q  <= pend_idx_d;
            pend_mask_q <= pend_mask_d;
            pend_data_q <= pend_data_d;
        end
    end

    // Array write port: byte-enabled drain of the pending buffer; contents survive reset
    always_ff @(posedge HCLK) begin
        for (int b = 0; b < BYTES; b++) begin
            if (drain && pend_mask_q[b]) mem_array[pend_idx_q][8*b +: 8] <= pend_data_q[8*b +: 8];
        end
    end

    assign HREADYOUT = !((state_q == S_WAIT) || (state_q == S_ERR1));
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA    = ((REGISTERED_OUTPUT == 0) && (state_q == S_DONE) && !write_q) ? read_out : hrdata_q;

endmodule
